sba_bus_adapter: RTL and testbench
==================================

SBA_BUS_ADAPTER -- requirements
Module: sba_bus_adapter

Interface
REQ-001 Parameter ADDR_LO, default 32'h0000_0000, lowest byte address forwarded to memory.
REQ-002 Parameter ADDR_HI, default 32'h0000_FFFF, highest byte address forwarded to memory (inclusive).
REQ-003 Parameter TIMEOUT_CYCLES, default 64, cycles allowed in REQ+WAIT before abort; legal range 2..65535.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk_i  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_i  in  1  synchronous reset, active high.
REQ-007 dm_req_i  in  1  debug-module system-bus master request.
REQ-008 dm_addr_i  in  32  byte address.
REQ-009 dm_we_i  in  1  1 = write, 0 = read.
REQ-010 dm_be_i  in  4  byte enables.
REQ-011 dm_wdata_i  in  32  write data.
REQ-012 dm_gnt_o  out  1  request accepted this cycle.
REQ-013 dm_rvalid_o  out  1  one-cycle response pulse.
REQ-014 dm_rdata_o  out  32  read data, valid with dm_rvalid_o.
REQ-015 dm_err_o  out  1  address-range error, valid with dm_rvalid_o.
REQ-016 dm_other_err_o  out  1  timeout error, valid with dm_rvalid_o.
REQ-017 mem_req_o, mem_addr_o[31:0], mem_we_o, mem_be_o[3:0], mem_wdata_o[31:0]  out  memory-side request.
REQ-018 mem_gnt_i, mem_rvalid_i, mem_rdata_i[31:0]  in  memory-side grant, response valid, and read data.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, RESP, ERR; one transaction outstanding at most.
REQ-020 dm_gnt_o SHALL equal (state==IDLE) & dm_req_i, combinationally; no grant in any other state.
REQ-021 On grant, the block SHALL latch addr/we/be/wdata; the range check is ADDR_LO <= addr <= ADDR_HI, unsigned 32-bit.
REQ-022 Grant with in-range address -> REQ next cycle; out-of-range -> ERR next cycle, with mem_req_o never asserted.
REQ-023 In REQ, mem_req_o SHALL be 1 with latched fields stable until mem_gnt_i.
REQ-024 REQ & mem_gnt_i & !mem_rvalid_i -> WAIT; REQ & mem_gnt_i & mem_rvalid_i (same cycle) -> RESP, capturing mem_rdata_i.
REQ-025 In WAIT, mem_req_o SHALL be 0; mem_rvalid_i -> RESP, capturing mem_rdata_i.
REQ-026 RESP: dm_rvalid_o=1 and both error flags 0 for exactly one cycle, then IDLE; dm_rdata_o = captured data for reads, 32'h0 for writes.
REQ-027 ERR: dm_rvalid_o=1 and dm_rdata_o=0 for exactly one cycle, then IDLE; dm_err_o=1 if the cause was range, dm_other_err_o=1 if the cause was timeout (never both).
REQ-028 Timeout counter: cleared on grant, increments each cycle in REQ or WAIT; on reaching TIMEOUT_CYCLES -> ERR(timeout), mem_req_o dropped the same cycle the counter reaches the limit.
REQ-029 mem_gnt_i or mem_rvalid_i arriving in the same cycle as the timeout limit SHALL take priority over the timeout (normal completion).
REQ-030 mem_rvalid_i arriving in IDLE/RESP/ERR (stale, post-timeout) SHALL be ignored with no output change.
REQ-031 dm_rdata_o/dm_err_o/dm_other_err_o SHALL be 0 whenever dm_rvalid_o=0.
REQ-032 Minimum latency, grant to dm_rvalid_o: 2 cycles (zero-wait memory); range error: 1 cycle.

Reset
REQ-033 rst_i high at a clock edge -> state IDLE, counter 0, all outputs 0, latched fields 0; this applies mid-transaction too, with mem_req_o falling in the cycle after the reset edge.
REQ-034 dm_gnt_o SHALL be 0 while rst_i=1.

Verification
REQ-035 Read 0x0000_0010, memory gnt same cycle as req, rvalid next cycle with 0xDEAD_BEEF -> dm_rvalid_o 3 cycles after grant, rdata 0xDEADBEEF, errs 0.
REQ-036 Write 0x0000_0020, be=4'b0011, wdata 0x1234_5678 -> mem_* carry those exact values; response rdata 0, errs 0.
REQ-037 Read 0x0001_0000 (above ADDR_HI) -> mem_req_o never 1; dm_rvalid_o 1 cycle after grant with dm_err_o=1.
REQ-038 TIMEOUT_CYCLES=4, mem_gnt_i held 0 -> mem_req_o high 4 cycles then low; dm_other_err_o=1 with rvalid; late rvalid ignored.
REQ-039 mem_gnt_i and mem_rvalid_i in the same REQ cycle -> RESP directly; dm_rvalid_o 2 cycles after grant.
REQ-040 rst_i asserted in WAIT -> IDLE, no dm_rvalid_o; next dm_req_i granted immediately.

Source files
------------

// File: rtl/sba_bus_adapter.sv
// Debug-module system-bus to single-port memory adapter: range check, one
// outstanding transaction, bounded wait with timeout abort.
module sba_bus_adapter #(
    parameter logic [31:0] ADDR_LO        = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI        = 32'h0000_FFFF,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        dm_req_i,
    input  logic [31:0] dm_addr_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_be_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_gnt_o,
    output logic        dm_rvalid_o,
    output logic [31:0] dm_rdata_o,
    output logic        dm_err_o,
    output logic        dm_other_err_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_t;

    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] SPAN        = ADDR_HI - ADDR_LO;
    localparam logic        RANGE_VALID = (ADDR_HI >= ADDR_LO);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_mem_req;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_other_err;

    logic        w_grant;
    logic [31:0] w_offset;
    logic        w_in_range;
    logic        w_cnt_last;

    assign w_grant    = (r_state == S_IDLE) & dm_req_i & ~rst_i;
    // Offset-from-base compare covers LO <= addr <= HI with a single unsigned test.
    assign w_offset   = dm_addr_i - ADDR_LO;
    assign w_in_range = RANGE_VALID && (w_offset <= SPAN);
    assign w_cnt_last = (r_cnt >= TO_LAST);

    assign dm_gnt_o       = w_grant;
    assign dm_rvalid_o    = r_rvalid;
    assign dm_rdata_o     = r_rdata;
    assign dm_err_o       = r_err;
    assign dm_other_err_o = r_other_err;
    assign mem_req_o      = r_mem_req;
    assign mem_addr_o     = r_addr;
    assign mem_we_o       = r_we;
    assign mem_be_o       = r_be;
    assign mem_wdata_o    = r_wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_mem_req   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_other_err <= 1'b0;
        end else begin
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_other_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_addr  <= dm_addr_i;
                        r_we    <= dm_we_i;
                        r_be    <= dm_be_i;
                        r_wdata <= dm_wdata_i;
                        r_cnt   <= '0;
                        if (w_in_range) begin
                            r_state   <= S_REQ;
                            r_mem_req <= 1'b1;
                        end else begin
                            r_state  <= S_ERR;
                            r_rvalid <= 1'b1;
                            r_err    <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 16'd1;
                    // Memory progress wins over a timeout landing in the same cycle.
                    if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        if (mem_rvalid_i) begin
                            r_state  <= S_RESP;
                            r_rvalid <= 1'b1;
                            r_rdata  <= r_we ? '0 : mem_rdata_i;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_cnt_last) begin
                        r_state     <= S_ERR;
                        r_mem_req   <= 1'b0;
                        r_rvalid    <= 1'b1;
                        r_other_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (mem_rvalid_i) begin
                        r_state  <= S_RESP;
                        r_rvalid <= 1'b1;
                        r_rdata  <= r_we ? '0 : mem_rdata_i;
                    end else if (w_cnt_last) begin
                        r_state     <= S_ERR;
                        r_rvalid    <= 1'b1;
                        r_other_err <= 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sba_bus_adapter.sv
// Randomized self-checking bench for sba_bus_adapter against a per-transaction
// timing model derived from memory grant/response delays.
module tb_sba_bus_adapter;

    localparam int unsigned T = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dm_req_i;
    logic [31:0] dm_addr_i;
    logic        dm_we_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_wdata_i;
    logic        dm_gnt_o;
    logic        dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        dm_err_o;
    logic        dm_other_err_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk_i = ~clk_i;

    sba_bus_adapter #(
        .ADDR_LO       (32'h0000_0000),
        .ADDR_HI       (32'h0000_FFFF),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .dm_req_i      (dm_req_i),
        .dm_addr_i     (dm_addr_i),
        .dm_we_i       (dm_we_i),
        .dm_be_i       (dm_be_i),
        .dm_wdata_i    (dm_wdata_i),
        .dm_gnt_o      (dm_gnt_o),
        .dm_rvalid_o   (dm_rvalid_o),
        .dm_rdata_o    (dm_rdata_o),
        .dm_err_o      (dm_err_o),
        .dm_other_err_o(dm_other_err_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rvalid"}, 32'(dm_rvalid_o), 32'd0);
        chk({tag, "_rdata"},  dm_rdata_o, 32'd0);
        chk({tag, "_err"},    32'(dm_err_o), 32'd0);
        chk({tag, "_oerr"},   32'(dm_other_err_o), 32'd0);
        chk({tag, "_mreq"},   32'(mem_req_o), 32'd0);
    endtask

    // g: cycles from first memory-request cycle until grant; r: cycles from
    // grant until read response. The response cycle follows from these alone.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input int unsigned g, input int unsigned r,
                           input logic [31:0] rd);
        bit          inr;
        bit          done;
        int unsigned resp_k;
        int unsigned req_last;
        inr      = (addr <= 32'h0000_FFFF);
        done     = inr && (g < T) && (g + r <= T - 1);
        resp_k   = !inr ? 1 : (done ? g + r + 2 : T + 1);
        req_last = (g < T) ? g : T - 1;

        dm_req_i   = 1'b1;
        dm_addr_i  = addr;
        dm_we_i    = we;
        dm_be_i    = be;
        dm_wdata_i = wd;
        #1;
        chk("gnt", 32'(dm_gnt_o), 32'd1);
        tick;
        dm_req_i   = 1'b0;
        dm_addr_i  = $urandom;
        dm_we_i    = ~we;
        dm_be_i    = ~be;
        dm_wdata_i = $urandom;
        for (int k = 1; k <= int'(T) + 6; k++) begin
            int unsigned i;
            bit          rv_now;
            bit          req_exp;
            i            = k - 1;
            rv_now       = (k == resp_k);
            req_exp      = inr && (i <= req_last);
            mem_gnt_i    = inr && (g < T) && (i == g);
            mem_rvalid_i = inr && (i == g + r);
            mem_rdata_i  = (i == g + r) ? rd : $urandom;
            #1;
            chk("gnt_busy", 32'(dm_gnt_o), 32'd0);
            chk("mem_req", 32'(mem_req_o), 32'(req_exp));
            if (req_exp) begin
                chk("mem_addr",  mem_addr_o, addr);
                chk("mem_we",    32'(mem_we_o), 32'(we));
                chk("mem_be",    32'(mem_be_o), 32'(be));
                chk("mem_wdata", mem_wdata_o, wd);
            end
            chk("rvalid", 32'(dm_rvalid_o), 32'(rv_now));
            chk("rdata",  dm_rdata_o, (rv_now && done && !we) ? rd : 32'd0);
            chk("err",    32'(dm_err_o), 32'(rv_now && !inr));
            chk("oerr",   32'(dm_other_err_o), 32'(rv_now && inr && !done));
            tick;
        end
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b1;
        dm_req_i     = 1'b1;
        dm_addr_i    = 32'h0000_0100;
        dm_we_i      = 1'b0;
        dm_be_i      = 4'hF;
        dm_wdata_i   = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        tick;
        tick;
        #1;
        chk("rst_gnt", 32'(dm_gnt_o), 32'd0);
        chk_idle_outputs("rst");
        chk("rst_maddr", mem_addr_o, 32'd0);
        chk("rst_mwdata", mem_wdata_o, 32'd0);
        rst_i    = 1'b0;
        dm_req_i = 1'b0;
        tick;

        run_txn(32'h0000_0010, 1'b0, 4'hF, 32'h0, 0, 1, 32'hDEAD_BEEF);
        run_txn(32'h0000_0020, 1'b1, 4'b0011, 32'h1234_5678, 0, 1, 32'hCAFE_F00D);
        run_txn(32'h0001_0000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0);
        run_txn(32'h0000_0030, 1'b0, 4'hF, 32'h0, T + 2, 0, 32'h5555_AAAA);
        run_txn(32'h0000_0040, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0BAD_F00D);
        run_txn(32'h0000_FFFF, 1'b0, 4'hF, 32'h0, T - 1, 0, 32'h8765_4321);
        run_txn(32'h0000_0000, 1'b0, 4'h1, 32'h0, 1, 2, 32'h0F0F_0F0F);
        run_txn(32'hFFFF_FFFF, 1'b1, 4'hF, 32'hFFFF_FFFF, 0, 0, 32'h0);
        run_txn(32'h0000_0044, 1'b0, 4'hF, 32'h0, 2, 2, 32'h1111_2222);

        // Reset while waiting for the memory response.
        dm_req_i  = 1'b1;
        dm_addr_i = 32'h0000_0080;
        dm_we_i   = 1'b0;
        #1;
        chk("w_gnt", 32'(dm_gnt_o), 32'd1);
        tick;
        dm_req_i  = 1'b0;
        mem_gnt_i = 1'b1;
        #1;
        chk("w_mreq", 32'(mem_req_o), 32'd1);
        tick;
        mem_gnt_i = 1'b0;
        rst_i     = 1'b1;
        dm_req_i  = 1'b1;
        #1;
        chk("w_gnt_rst", 32'(dm_gnt_o), 32'd0);
        chk("w_mreq_wait", 32'(mem_req_o), 32'd0);
        tick;
        rst_i        = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBEEF_0000;
        #1;
        chk_idle_outputs("w_post");
        chk("w_post_gnt", 32'(dm_gnt_o), 32'd1);
        mem_rvalid_i = 1'b0;
        run_txn(32'h0000_0084, 1'b0, 4'hF, 32'h0, 0, 1, 32'h2468_ACE0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int unsigned g;
            int unsigned r;
            if ($urandom_range(0, 3) == 0) a = $urandom | 32'h0001_0000;
            else                           a = $urandom & 32'h0000_FFFC;
            g = $urandom_range(0, T + 1);
            r = (g == T - 1) ? 0 : $urandom_range(0, 3);
            run_txn(a, 1'($urandom), 4'($urandom), $urandom, g, r, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
